// File: rtl/alu_multicycle.sv
// Multicycle datapath ALU: single-cycle logic/arith ops, iterative one-bit-per-cycle
// shifts, result held behind a valid/ready handshake.
//
// state | meaning
// IDLE  | ready for a new request (in_ready=1)
// SHIFT | shifting the captured operand one position per cycle
// DONE  | result presented (out_valid=1), held until out_ready
module alu_multicycle #(
   parameter int DATA_WIDTH = 32,
   parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [3:0]            Operation,
   input  logic [DATA_WIDTH-1:0] SrcA,
   input  logic [DATA_WIDTH-1:0] SrcB,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] ALUResult,
   output logic                  Zero,
   output logic                  Illegal
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_XOR  = 4'b0011;
   localparam logic [3:0] OP_SLL  = 4'b0100;
   localparam logic [3:0] OP_SRL  = 4'b0101;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_SLT2 = 4'b1111;
   localparam logic [3:0] OP_EQ   = 4'b1000;
   localparam logic [3:0] OP_SRA  = 4'b1001;

   state_t                r_state;
   logic [DATA_WIDTH-1:0] r_acc;
   logic [SHAMT_W-1:0]    r_cnt;
   logic [3:0]            r_op;
   logic                  r_zero;
   logic                  r_illegal;

   state_t                w_state_nxt;
   logic [DATA_WIDTH-1:0] w_acc_nxt;
   logic [SHAMT_W-1:0]    w_cnt_nxt;
   logic [3:0]            w_op_nxt;
   logic                  w_zero_nxt;
   logic                  w_illegal_nxt;

   logic [DATA_WIDTH-1:0] w_alu;
   logic                  w_is_shift;
   logic                  w_bad_op;
   logic [DATA_WIDTH-1:0] w_shift1;
   logic [SHAMT_W-1:0]    w_shamt;

   assign w_shamt = SrcB[SHAMT_W-1:0];

   // Single-cycle ops; shift codes only flag w_is_shift, the shifter does the work.
   always_comb begin
      w_alu      = '0;
      w_is_shift = 1'b0;
      w_bad_op   = 1'b0;
      case (Operation)
         OP_AND:          w_alu = SrcA & SrcB;
         OP_OR:           w_alu = SrcA | SrcB;
         OP_ADD:          w_alu = SrcA + SrcB;
         OP_XOR:          w_alu = SrcA ^ SrcB;
         OP_SUB:          w_alu = SrcA - SrcB;
         OP_SLT, OP_SLT2: w_alu = DATA_WIDTH'($signed(SrcA) < $signed(SrcB));
         OP_EQ:           w_alu = DATA_WIDTH'(SrcA == SrcB);
         OP_SLL, OP_SRL, OP_SRA: w_is_shift = 1'b1;
         default:         w_bad_op = 1'b1;
      endcase
   end

   always_comb begin
      w_shift1 = r_acc;
      case (r_op)
         OP_SLL:  w_shift1 = {r_acc[DATA_WIDTH-2:0], 1'b0};
         OP_SRL:  w_shift1 = {1'b0, r_acc[DATA_WIDTH-1:1]};
         OP_SRA:  w_shift1 = {r_acc[DATA_WIDTH-1], r_acc[DATA_WIDTH-1:1]};
         default: w_shift1 = r_acc;
      endcase
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_acc_nxt     = r_acc;
      w_cnt_nxt     = r_cnt;
      w_op_nxt      = r_op;
      w_zero_nxt    = r_zero;
      w_illegal_nxt = r_illegal;
      in_ready      = 1'b0;
      out_valid     = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_op_nxt = Operation;
               if (w_is_shift) begin
                  w_acc_nxt     = SrcA;
                  w_cnt_nxt     = w_shamt;
                  w_illegal_nxt = 1'b0;
                  if (w_shamt == '0) begin
                     w_zero_nxt  = (SrcA == '0);
                     w_state_nxt = DONE;
                  end else begin
                     w_state_nxt = SHIFT;
                  end
               end else begin
                  w_acc_nxt     = w_alu;
                  w_zero_nxt    = (w_alu == '0);
                  w_illegal_nxt = w_bad_op;
                  w_state_nxt   = DONE;
               end
            end
         end
         SHIFT: begin
            w_acc_nxt = w_shift1;
            w_cnt_nxt = r_cnt - SHAMT_W'(1);
            if (r_cnt == SHAMT_W'(1)) begin
               w_zero_nxt  = (w_shift1 == '0);
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_acc     <= '0;
         r_cnt     <= '0;
         r_op      <= '0;
         r_zero    <= 1'b0;
         r_illegal <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_acc     <= w_acc_nxt;
         r_cnt     <= w_cnt_nxt;
         r_op      <= w_op_nxt;
         r_zero    <= w_zero_nxt;
         r_illegal <= w_illegal_nxt;
      end
   end

   assign ALUResult = r_acc;
   assign Zero      = r_zero;
   assign Illegal   = r_illegal;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed-vector bench for alu_multicycle: each scenario task checks its own results.
module tb_alu_multicycle;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  Operation;
   logic [31:0] SrcA;
   logic [31:0] SrcB;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] ALUResult;
   logic        Zero;
   logic        Illegal;

   int checks;
   int failures;

   alu_multicycle #(.DATA_WIDTH(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .Operation (Operation),
      .SrcA      (SrcA),
      .SrcB      (SrcB),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .ALUResult (ALUResult),
      .Zero      (Zero),
      .Illegal   (Illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accepts one request from IDLE, scrambles the inputs, returns cycles until out_valid (-1 on timeout).
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat);
      Operation = op;
      SrcA      = a;
      SrcB      = b;
      in_valid  = 1'b1;
      tick();
      in_valid  = 1'b0;
      Operation = 4'b0011;
      SrcA      = 32'hDEAD_BEEF;
      SrcB      = 32'h0000_0005;
      lat = 1;
      while (!out_valid && lat < 100) begin
         tick();
         lat++;
      end
      if (!out_valid) lat = -1;
   endtask

   task automatic finish_op();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      checks++;
      if (out_valid !== 1'b0 || ALUResult !== 32'h0 || Zero !== 1'b0 || Illegal !== 1'b0) begin
         failures++;
         $display("FAIL reset_outputs: got ov=%b res=%h z=%b ill=%b, want 0 0 0 0",
                  out_valid, ALUResult, Zero, Illegal);
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
   endtask

   task automatic test_add_sub();
      int lat;
      run_op(4'b0010, 32'h7FFF_FFFF, 32'h1, lat);
      checks++;
      if (lat !== 1 || ALUResult !== 32'h8000_0000 || Zero !== 1'b0 || Illegal !== 1'b0) begin
         failures++;
         $display("FAIL add_wrap: got lat=%0d res=%h z=%b ill=%b, want 1 80000000 0 0",
                  lat, ALUResult, Zero, Illegal);
      end
      finish_op();
      run_op(4'b0110, 32'h5, 32'h5, lat);
      checks++;
      if (lat !== 1 || ALUResult !== 32'h0 || Zero !== 1'b1) begin
         failures++;
         $display("FAIL sub_zero: got lat=%0d res=%h z=%b, want 1 0 1", lat, ALUResult, Zero);
      end
      finish_op();
   endtask

   task automatic test_slt_eq();
      int lat;
      run_op(4'b0111, 32'hFFFF_FFFF, 32'h1, lat);
      checks++;
      if (lat !== 1 || ALUResult !== 32'h1) begin
         failures++;
         $display("FAIL slt_neg: got lat=%0d res=%h, want 1 1", lat, ALUResult);
      end
      finish_op();
      run_op(4'b1111, 32'hFFFF_FFFF, 32'h1, lat);
      checks++;
      if (lat !== 1 || ALUResult !== 32'h1) begin
         failures++;
         $display("FAIL slt_alias: got lat=%0d res=%h, want 1 1", lat, ALUResult);
      end
      finish_op();
      run_op(4'b0111, 32'h1, 32'hFFFF_FFFF, lat);
      checks++;
      if (lat !== 1 || ALUResult !== 32'h0 || Zero !== 1'b1) begin
         failures++;
         $display("FAIL slt_pos: got lat=%0d res=%h z=%b, want 1 0 1", lat, ALUResult, Zero);
      end
      finish_op();
      run_op(4'b1000, 32'h1234, 32'h1234, lat);
      checks++;
      if (lat !== 1 || ALUResult !== 32'h1 || Zero !== 1'b0) begin
         failures++;
         $display("FAIL eq_equal: got lat=%0d res=%h z=%b, want 1 1 0", lat, ALUResult, Zero);
      end
      finish_op();
      run_op(4'b0001, 32'h00F0_0000, 32'h0000_000F, lat);
      checks++;
      if (lat !== 1 || ALUResult !== 32'h00F0_000F) begin
         failures++;
         $display("FAIL or_basic: got lat=%0d res=%h, want 1 00f0000f", lat, ALUResult);
      end
      finish_op();
   endtask

   task automatic test_shifts();
      int lat;
      run_op(4'b1001, 32'h8000_0000, 32'h4, lat);
      checks++;
      if (lat !== 5 || ALUResult !== 32'hF800_0000 || Zero !== 1'b0) begin
         failures++;
         $display("FAIL sra_4: got lat=%0d res=%h z=%b, want 5 f8000000 0", lat, ALUResult, Zero);
      end
      finish_op();
      run_op(4'b0101, 32'h8000_0000, 32'd31, lat);
      checks++;
      if (lat !== 32 || ALUResult !== 32'h1 || Zero !== 1'b0) begin
         failures++;
         $display("FAIL srl_31: got lat=%0d res=%h z=%b, want 32 1 0", lat, ALUResult, Zero);
      end
      finish_op();
      run_op(4'b0100, 32'h1, 32'h20, lat);
      checks++;
      if (lat !== 1 || ALUResult !== 32'h1) begin
         failures++;
         $display("FAIL sll_shamt0: got lat=%0d res=%h, want 1 1", lat, ALUResult);
      end
      finish_op();
      run_op(4'b0100, 32'h8000_0003, 32'h4, lat);
      checks++;
      if (lat !== 5 || ALUResult !== 32'h0000_0030) begin
         failures++;
         $display("FAIL sll_4: got lat=%0d res=%h, want 5 00000030", lat, ALUResult);
      end
      finish_op();
      run_op(4'b0101, 32'h0000_0008, 32'h4, lat);
      checks++;
      if (lat !== 5 || ALUResult !== 32'h0 || Zero !== 1'b1) begin
         failures++;
         $display("FAIL srl_to_zero: got lat=%0d res=%h z=%b, want 5 0 1", lat, ALUResult, Zero);
      end
      finish_op();
   endtask

   task automatic test_backpressure();
      int lat;
      int bad;
      run_op(4'b0011, 32'h0F0F, 32'hFFFF, lat);
      Operation = 4'b0010;
      SrcA      = 32'h1;
      SrcB      = 32'h1;
      in_valid  = 1'b1;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (out_valid !== 1'b1 || ALUResult !== 32'hF0F0 || in_ready !== 1'b0) bad++;
         tick();
      end
      checks++;
      if (lat !== 1 || bad !== 0) begin
         failures++;
         $display("FAIL xor_hold: got lat=%0d bad_cycles=%0d res=%h, want 1 0 0000f0f0",
                  lat, bad, ALUResult);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL bp_release: got ov=%b ir=%b, want 0 1", out_valid, in_ready);
      end
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || ALUResult !== 32'h2) begin
         failures++;
         $display("FAIL bp_second: got ov=%b res=%h, want 1 2", out_valid, ALUResult);
      end
      finish_op();
   endtask

   task automatic test_back_to_back();
      int lat;
      run_op(4'b0000, 32'hFF00_FF00, 32'h0FF0_0FF0, lat);
      checks++;
      if (lat !== 1 || ALUResult !== 32'h0F00_0F00) begin
         failures++;
         $display("FAIL and_b2b: got lat=%0d res=%h, want 1 0f000f00", lat, ALUResult);
      end
      finish_op();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL b2b_idle: got ir=%b ov=%b, want 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_illegal();
      int lat;
      run_op(4'b1010, 32'h1234_5678, 32'h1, lat);
      checks++;
      if (lat !== 1 || ALUResult !== 32'h0 || Illegal !== 1'b1 || Zero !== 1'b1) begin
         failures++;
         $display("FAIL illegal_op: got lat=%0d res=%h ill=%b z=%b, want 1 0 1 1",
                  lat, ALUResult, Illegal, Zero);
      end
      finish_op();
      run_op(4'b0000, 32'hFF, 32'h0F, lat);
      checks++;
      if (lat !== 1 || ALUResult !== 32'h0F || Illegal !== 1'b0 || Zero !== 1'b0) begin
         failures++;
         $display("FAIL illegal_clear: got lat=%0d res=%h ill=%b z=%b, want 1 0000000f 0 0",
                  lat, ALUResult, Illegal, Zero);
      end
      finish_op();
   endtask

   task automatic test_reset_mid_shift();
      int lat;
      int seen;
      Operation = 4'b0100;
      SrcA      = 32'h1;
      SrcB      = 32'd20;
      in_valid  = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      rst_n = 1'b0;
      tick();
      checks++;
      if (out_valid !== 1'b0 || ALUResult !== 32'h0 || Zero !== 1'b0 || Illegal !== 1'b0) begin
         failures++;
         $display("FAIL midrst_outputs: got ov=%b res=%h z=%b ill=%b, want 0 0 0 0",
                  out_valid, ALUResult, Zero, Illegal);
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL midrst_in_ready: got %b want 1", in_ready);
      end
      seen = 0;
      for (int i = 0; i < 25; i++) begin
         if (out_valid !== 1'b0) seen++;
         tick();
      end
      checks++;
      if (seen !== 0) begin
         failures++;
         $display("FAIL midrst_no_result: got %0d valid cycles, want 0", seen);
      end
      run_op(4'b0010, 32'h2, 32'h3, lat);
      checks++;
      if (lat !== 1 || ALUResult !== 32'h5) begin
         failures++;
         $display("FAIL midrst_add: got lat=%0d res=%h, want 1 5", lat, ALUResult);
      end
      finish_op();
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      Operation = 4'b0000;
      SrcA      = 32'h0;
      SrcB      = 32'h0;
      test_reset();
      test_add_sub();
      test_slt_eq();
      test_shifts();
      test_backpressure();
      test_back_to_back();
      test_illegal();
      test_reset_mid_shift();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
